// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: PC source encodings, FSM state
// type and default sizing.
package fetch_sequencer_pkg;

  // Next-PC source select driven to Fetch
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_STACK  = 2'b11;

  localparam int DEF_STACK_DEPTH = 8;
  localparam int DEF_ADDR_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_REDIRECT = 2'b10,
    ST_FAULT    = 2'b11
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Request/response bundle between the pipeline (master) and the fetch
// sequencer (slave). Optional counters appear when FETCH_SEQ_PERF_EN is defined.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              dec_valid;
  logic              dec_jump;
  logic              dec_call;
  logic              dec_ret;
  logic [ADDR_W-1:0] dec_ret_addr;
  logic              ex_branch_taken;
  logic [1:0]        PCsrc;
  logic [ADDR_W-1:0] PCstack;
  logic              pc_en;
  logic              flush;
  logic              fault;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]       redirect_cnt;
  logic [31:0]       stall_cnt;
`endif

  modport master (
    output stall, dec_valid, dec_jump, dec_call, dec_ret, dec_ret_addr, ex_branch_taken,
    input  PCsrc, PCstack, pc_en, flush, fault
`ifdef FETCH_SEQ_PERF_EN
    , input redirect_cnt, stall_cnt
`endif
  );

  modport slave (
    input  stall, dec_valid, dec_jump, dec_call, dec_ret, dec_ret_addr, ex_branch_taken,
    output PCsrc, PCstack, pc_en, flush, fault
`ifdef FETCH_SEQ_PERF_EN
    , output redirect_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/fetch_sequencer_return_stack.sv
// Hardware call/return LIFO. Top is visible combinationally as entry[sp-1]
// and reads zero when empty. Push on full and pop on empty are ignored.
module return_stack
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH  = DEF_STACK_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] top_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  top_idx_s;

  assign full_o    = (sp_q == SP_FULL);
  assign empty_o   = (sp_q == '0);
  assign top_idx_s = sp_q[IDX_W-1:0] - IDX_ONE;
  assign top_o     = empty_o ? '0 : mem_q[top_idx_s];

  // Stack pointer next-state: push and pop never wrap past the ends
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SP_ONE;
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SP_ONE;
    end else begin
      sp_d = sp_q;
    end
  end

  // Stack pointer register; reset empties the stack
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage written at the current free slot on push
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      mem_q[sp_q[IDX_W-1:0]] <= data_i;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: arbitrates branch/call/ret/jump redirects, gates PC update,
// issues flushes and owns the return stack. Optional performance counters are
// built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.slave bus
);
  state_t            state_q, state_d;
  logic [1:0]        pcsrc_s;
  logic              pc_en_s;
  logic              flush_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [ADDR_W-1:0] top_s;

  return_stack #(.DEPTH(STACK_DEPTH), .ADDR_W(ADDR_W)) u_stack (
    .clk_i   (clk),
    .rst_n_i (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (bus.dec_ret_addr),
    .full_o  (full_s),
    .empty_o (empty_s),
    .top_o   (top_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect arbitration: taken branch > stall > call > ret > jump > sequential
  always_comb begin
    state_d = state_q;
    pcsrc_s = PC_SEQ;
    pc_en_s = 1'b0;
    flush_s = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          pcsrc_s = PC_BRANCH;
          pc_en_s = 1'b1;
          flush_s = 1'b1;
          state_d = ST_REDIRECT;
        end else if (bus.stall) begin
          pc_en_s = 1'b0;
        end else if (bus.dec_valid && bus.dec_call) begin
          if (full_s) begin
            state_d = ST_FAULT;
          end else begin
            push_s  = 1'b1;
            pcsrc_s = PC_JUMP;
            pc_en_s = 1'b1;
            state_d = ST_REDIRECT;
          end
        end else if (bus.dec_valid && bus.dec_ret) begin
          if (empty_s) begin
            state_d = ST_FAULT;
          end else begin
            pop_s   = 1'b1;
            pcsrc_s = PC_STACK;
            pc_en_s = 1'b1;
            state_d = ST_REDIRECT;
          end
        end else if (bus.dec_valid && bus.dec_jump) begin
          pcsrc_s = PC_JUMP;
          pc_en_s = 1'b1;
          state_d = ST_REDIRECT;
        end else begin
          pc_en_s = 1'b1;
        end
      end
      ST_REDIRECT: begin
        // Wrong-path fetch is killed; decode requests are not acted on here
        flush_s = 1'b1;
        if (bus.ex_branch_taken) begin
          pcsrc_s = PC_BRANCH;
          pc_en_s = 1'b1;
          state_d = ST_REDIRECT;
        end else begin
          pc_en_s = !bus.stall;
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        flush_s = 1'b1;
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.PCsrc   = pcsrc_s;
  assign bus.pc_en   = pc_en_s;
  assign bus.flush   = flush_s;
  assign bus.fault   = (state_q == ST_FAULT);
  assign bus.PCstack = top_s;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        active_s;

  assign active_s = (state_q == ST_RUN) || (state_q == ST_REDIRECT);

  // Event counters: redirect entries and stalled active cycles, free-running wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      if (active_s && (state_d == ST_REDIRECT)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
      if (active_s && bus.stall && !bus.ex_branch_taken) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
`endif
endmodule
